max_pool_stream: RTL and testbench
==================================

Name: max_pool_stream

Overview:
Streaming 2x2 stride-2 max-pooling engine for multi-bit, multi-channel feature maps.
- Parametrised successor to the single-bit 2x2 pooling cell.
- Accepts pixels in raster order over a valid/ready interface.
- Holds pairwise row maxima in a half-width line buffer.
- Emits one pooled pixel per 2x2 window over a registered valid/ready output.
- Sits between a convolution/activation stage and the next layer's input.

Parameters:
DATA_W, 8, bits per channel element
CH, 1, channels packed per pixel (element c at bits [c*DATA_W +: DATA_W])
IMG_W, 8, input image width in pixels (even, >=2)
IMG_H, 8, input image height in pixels (even, >=2)
SIGNED, 0, 1 = two's-complement compare; 0 = unsigned compare

Ports:
clk  in  1  clock, rising edge
n_rst  in  1  asynchronous active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel this cycle
in_sof  in  1  start of frame; qualifies the accepted pixel as (row 0, col 0)
in_data  in  CH*DATA_W  input pixel
out_valid  out  1  pooled pixel valid
out_ready  in  1  downstream accepts the pooled pixel
out_data  out  CH*DATA_W  pooled pixel
out_last  out  1  final pooled pixel of the frame

Behaviour:
- Reset (async, n_rst=0):
  - out_valid=0, out_data=0, out_last=0.
  - col/row counters=0; line buffer contents don't-care.
  - in_ready=1 one cycle after deassertion.
- Handshakes:
  - Input accepted when in_valid & in_ready; output transferred when out_valid & out_ready.
  - in_ready = ~out_valid | out_ready. Conservative: applies to every pixel, not only window-completing ones.
  - out_valid, out_data and out_last stay stable while out_valid & ~out_ready.
- Counters:
  - col 0..IMG_W-1; row 0..IMG_H-1; advance on each accepted pixel.
  - col wraps at IMG_W-1 and increments row; row wraps at IMG_H-1 to 0.
  - Accepted pixel with in_sof=1 is treated as (0,0) regardless of counters; counters become (0,1) afterwards. in_sof mid-frame discards the partial window and line-buffer state logically.
- Datapath, per channel independently, compare per SIGNED:
  - even col: hold pixel in pair register P.
  - odd col: h = max(P, pixel).
  - even row: line buffer entry LB[col>>1] = h.
  - odd row: result = max(LB[col>>1], h). Load the output register and set out_valid=1 on the cycle following acceptance (latency 1 cycle from the 4th window pixel).
  - out_last=1 with the output for row IMG_H-1, col IMG_W-1; otherwise 0.
- Simultaneous events: an output transfer and a new load in the same cycle is allowed (in_ready=1 via out_ready); the new value replaces the old one, with no bubble.
- Ties: equal values yield that value.
- Full throughput: 1 input/cycle, with outputs at 1/4 input rate when out_ready=1.
- Reset mid-frame: everything aborts, no partial output; the next frame must start with in_sof or from counter (0,0).

Decomposition:
- Package pool_pkg:
  - pixel_t / elem_t typedefs parametrised via localparams.
  - Function elem_max(a, b, is_signed).
  - Localparam LB_DEPTH = IMG_W/2.
- Sub-module pool_line_buf:
  - LB_DEPTH x CH*DATA_W register array.
  - One write port and one combinational read port, addressed by col>>1.
  - Reset-free storage.

Test Plan:
- 4x4, DATA_W=8, CH=1, rows [1 2 3 4 / 5 6 7 8 / 9 10 11 12 / 13 14 15 16], in_sof on the first pixel, out_ready=1 -> outputs 6, 8, 14, 16 in order; out_last only on 16; out_valid one cycle after pixels 6, 8, 14, 16 are accepted.
- SIGNED=1, 2x2 input -3, -1, -2, -4 (0xFD, 0xFF, 0xFE, 0xFC) -> output 0xFF (-1). Same data with SIGNED=0 -> 0xFF (255). Input 0x80, 0x01, 0x01, 0x01 with SIGNED=1 -> 0x01, with SIGNED=0 -> 0x80.
- CH=2, pixel halves {hi,lo}: {9,1}, {2,7}, {3,3}, {4,8} -> out_data {9,8}.
- Backpressure: hold out_ready=0 after the first output of the 4x4 frame -> in_ready=0 and out_data stays 6 until out_ready=1. Stream then resumes and produces 8, 14, 16 with no loss or duplication.
- Assert in_sof at 4x4 frame pixel (1,1) with new frame all 20 -> first output is 20, not a mix with the old frame. Inject n_rst low mid-frame -> out_valid falls immediately, and a fresh frame produces a correct output sequence.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming 2x2 max-pool engine.
// - Default geometry localparams. The top overrides them with its own parameters.
// - elem_t: a wide container used by elem_max. Any DATA_W up to MAX_ELEM_W
//   is zero-extended into it.
// - elem_max: a signed or unsigned maximum of two w-bit elements.
package pool_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CH     = 1;
    localparam int DEF_IMG_W  = 8;
    localparam int DEF_IMG_H  = 8;
    localparam int LB_DEPTH   = DEF_IMG_W / 2;
    localparam int MAX_ELEM_W = 32;

    typedef logic [MAX_ELEM_W-1:0]        elem_t;
    typedef logic [DEF_CH*DEF_DATA_W-1:0] pixel_t;

    // Inputs are zero-extended w-bit values. Flipping the element's sign bit
    // turns a two's-complement order into an unsigned order. One comparator
    // therefore serves both modes. On a tie, a is returned, which equals b.
    function automatic elem_t elem_max(elem_t a, elem_t b, logic is_signed, int unsigned w);
        elem_t flip;
        flip = is_signed ? (elem_t'(1) << (w - 1)) : '0;
        return ((a ^ flip) >= (b ^ flip)) ? a : b;
    endfunction
endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer that holds the horizontal pair maxima of an even row.
// Ports:
//   clk      - clock
//   wr_en    - write strobe
//   wr_addr  - write index (col>>1)
//   wr_data  - pair maximum to store
//   rd_addr  - read index (col>>1)
//   rd_data  - combinational read data
// The storage has no reset. Every entry is rewritten in an even row before
// an odd row reads it.
module pool_line_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/max_pool_stream.sv
// Streaming 2x2, stride-2 max-pooling engine.
// - Pixels arrive in raster order. Each 2x2 window yields one pooled pixel.
// Ports:
//   clk, n_rst            - clock and asynchronous active-low reset
//   in_valid/in_ready     - input handshake
//   in_sof                - forces the accepted pixel to position (0,0)
//   in_data               - CH packed elements of DATA_W bits each
//   out_valid/out_ready   - output handshake, registered
//   out_data, out_last    - pooled pixel, and the flag for the last pixel of the frame
module max_pool_stream
    import pool_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH     = DEF_CH,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic [CH*DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DATA_W-1:0] out_data,
    output logic                 out_last
);
    localparam int PW  = CH * DATA_W;
    localparam int LBD = IMG_W / 2;
    localparam int CW  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int AW  = (LBD > 1) ? $clog2(LBD) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic          rdy_q;
    logic [CW-1:0] col_q, col_d, eff_col;
    logic [RW-1:0] row_q, row_d, eff_row;
    logic [PW-1:0] pair_q, pair_d, h_w, res_w, lb_rd;
    logic [PW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic          acc, lb_we;
    logic [AW-1:0] lb_addr;

    // rdy_q holds in_ready low while reset is asserted and releases it on
    // the first clock after reset. The output stage only accepts a new pixel
    // when its register is empty or is being drained in the same cycle.
    assign in_ready = rdy_q & (~out_valid_q | out_ready);
    assign acc      = in_valid & in_ready;

    // A start-of-frame pixel overrides the counters. The stale pair register
    // and line-buffer entries are overwritten before they are read again.
    assign eff_col = in_sof ? '0 : col_q;
    assign eff_row = in_sof ? '0 : row_q;
    assign lb_addr = AW'(eff_col >> 1);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign h_w[c*DATA_W +: DATA_W] = DATA_W'(elem_max(
            elem_t'(pair_q[c*DATA_W +: DATA_W]), elem_t'(in_data[c*DATA_W +: DATA_W]),
            SIGNED != 0, DATA_W));
        assign res_w[c*DATA_W +: DATA_W] = DATA_W'(elem_max(
            elem_t'(lb_rd[c*DATA_W +: DATA_W]), elem_t'(h_w[c*DATA_W +: DATA_W]),
            SIGNED != 0, DATA_W));
    end

    pool_line_buf #(.W(PW), .DEPTH(LBD), .AW(AW)) u_lb (
        .clk     (clk),
        .wr_en   (lb_we),
        .wr_addr (lb_addr),
        .wr_data (h_w),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        lb_we       = 1'b0;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q & ~out_ready;
        if (acc) begin
            if (eff_col == COL_LAST) begin
                col_d = '0;
                row_d = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col_d = eff_col + 1'b1;
                row_d = eff_row;
            end
            if (!eff_col[0]) begin
                pair_d = in_data;
            end else if (!eff_row[0]) begin
                lb_we = 1'b1;
            end else begin
                // The fourth pixel of the window completes it. A load here
                // overrides any drain in the same cycle, so there is no bubble.
                out_valid_d = 1'b1;
                out_data_d  = res_w;
                out_last_d  = (eff_row == ROW_LAST) && (eff_col == COL_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdy_q       <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            rdy_q       <= 1'b1;
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream.
// - A 4x4 unsigned instance runs the streaming, backpressure, sof and reset scenarios.
// - Three 2x2 instances cover signed compare, unsigned compare and CH=2.
// - Expected outputs ({last, data}) go into queues. Per-instance monitors pop
//   and compare on each output transfer.
module tb_max_pool_stream;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic       m_iv = 1'b0, m_sof = 1'b0, m_or = 1'b1;
    logic [7:0] m_id = '0;
    logic       m_ir, m_ov, m_last;
    logic [7:0] m_od;

    logic        s_iv = 1'b0, s_sof = 1'b0;
    logic [7:0]  s_d = '0;
    logic [15:0] c_d = '0;
    logic        s1_ir, s1_ov, s1_last, s0_ir, s0_ov, s0_last, c2_ir, c2_ov, c2_last;
    logic [7:0]  s1_od, s0_od;
    logic [15:0] c2_od;

    max_pool_stream #(.DATA_W(8), .CH(1), .IMG_W(4), .IMG_H(4), .SIGNED(0)) u_main (
        .clk(clk), .n_rst(n_rst), .in_valid(m_iv), .in_ready(m_ir), .in_sof(m_sof),
        .in_data(m_id), .out_valid(m_ov), .out_ready(m_or), .out_data(m_od), .out_last(m_last));
    max_pool_stream #(.DATA_W(8), .CH(1), .IMG_W(2), .IMG_H(2), .SIGNED(1)) u_s1 (
        .clk(clk), .n_rst(n_rst), .in_valid(s_iv), .in_ready(s1_ir), .in_sof(s_sof),
        .in_data(s_d), .out_valid(s1_ov), .out_ready(1'b1), .out_data(s1_od), .out_last(s1_last));
    max_pool_stream #(.DATA_W(8), .CH(1), .IMG_W(2), .IMG_H(2), .SIGNED(0)) u_s0 (
        .clk(clk), .n_rst(n_rst), .in_valid(s_iv), .in_ready(s0_ir), .in_sof(s_sof),
        .in_data(s_d), .out_valid(s0_ov), .out_ready(1'b1), .out_data(s0_od), .out_last(s0_last));
    max_pool_stream #(.DATA_W(8), .CH(2), .IMG_W(2), .IMG_H(2), .SIGNED(0)) u_c2 (
        .clk(clk), .n_rst(n_rst), .in_valid(s_iv), .in_ready(c2_ir), .in_sof(s_sof),
        .in_data(c_d), .out_valid(c2_ov), .out_ready(1'b1), .out_data(c2_od), .out_last(c2_last));

    int n_tests = 0;
    int n_fail  = 0;
    // Entry format: bit 16 = last, bits 15:0 = data.
    logic [31:0] q_main[$], q_s1[$], q_s0[$], q_c2[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got output %0h expected none", nm, act);
    endtask

    // Monitors sample 1 time unit after the falling edge. Inputs only change
    // on the falling edge, so a transfer seen here completes on the next rising edge.
    always begin : mon
        logic [31:0] e;
        @(negedge clk); #1;
        if (n_rst && m_ov && m_or) begin
            if (q_main.size() == 0) unexpected("main_out", 32'(m_od));
            else begin
                e = q_main.pop_front();
                chk("main_data", 32'(m_od), 32'(e[7:0]));
                chk("main_last", 32'(m_last), 32'(e[16]));
            end
        end
        if (n_rst && s1_ov) begin
            if (q_s1.size() == 0) unexpected("s1_out", 32'(s1_od));
            else begin
                e = q_s1.pop_front();
                chk("signed_data", 32'(s1_od), 32'(e[7:0]));
                chk("signed_last", 32'(s1_last), 32'(e[16]));
            end
        end
        if (n_rst && s0_ov) begin
            if (q_s0.size() == 0) unexpected("s0_out", 32'(s0_od));
            else begin
                e = q_s0.pop_front();
                chk("unsigned_data", 32'(s0_od), 32'(e[7:0]));
            end
        end
        if (n_rst && c2_ov) begin
            if (q_c2.size() == 0) unexpected("c2_out", 32'(c2_od));
            else begin
                e = q_c2.pop_front();
                chk("ch2_data", 32'(c2_od), 32'(e[15:0]));
            end
        end
    end

    // Sends one pixel to the 4x4 instance. Waits a bounded time for in_ready.
    // exp_ov >= 0 also checks out_valid just after the accepting edge.
    task automatic m_send(input logic [7:0] d, input logic sof, input int exp_ov);
        int t = 0;
        @(negedge clk);
        m_iv = 1'b1; m_id = d; m_sof = sof;
        #1;
        while (!m_ir) begin
            if (t == 200) begin
                unexpected("main_in_ready_timeout", 32'(d));
                m_iv = 1'b0;
                return;
            end
            @(negedge clk); #1;
            t++;
        end
        @(posedge clk); #1;
        m_iv = 1'b0; m_sof = 1'b0;
        if (exp_ov >= 0) chk("main_latency", 32'(m_ov), 32'(exp_ov[0]));
    endtask

    task automatic s_send(input logic [7:0] d, input logic [15:0] c, input logic sof);
        @(negedge clk);
        s_iv = 1'b1; s_d = d; c_d = c; s_sof = sof;
        #1;
        chk("small_in_ready", 32'({s1_ir, s0_ir, c2_ir}), 32'h7);
        @(posedge clk); #1;
        s_iv = 1'b0; s_sof = 1'b0;
    endtask

    task automatic push_std();
        q_main.push_back(32'h00006); q_main.push_back(32'h00008);
        q_main.push_back(32'h0000E); q_main.push_back(32'h10010);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        #12;
        chk("rst_out_valid", 32'(m_ov), 32'h0);
        chk("rst_out_data", 32'(m_od), 32'h0);
        chk("rst_out_last", 32'(m_last), 32'h0);
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(m_ir), 32'h1);

        // Frame 1: streaming with out_ready=1. out_valid rises right after pixels 6, 8, 14 and 16.
        push_std();
        for (int i = 0; i < 16; i++)
            m_send(8'(i + 1), i == 0, (i == 5 || i == 7 || i == 13 || i == 15) ? 1 : 0);
        repeat (3) @(negedge clk);

        // Frame 2: hold the first output under backpressure.
        m_or = 1'b0;
        push_std();
        for (int i = 0; i < 6; i++) m_send(8'(i + 1), i == 0, -1);
        repeat (3) begin
            @(negedge clk); #1;
            chk("bp_in_ready", 32'(m_ir), 32'h0);
            chk("bp_out_valid", 32'(m_ov), 32'h1);
            chk("bp_out_data", 32'(m_od), 32'h6);
        end
        @(negedge clk); m_or = 1'b1;
        for (int i = 6; i < 16; i++) m_send(8'(i + 1), 1'b0, -1);
        repeat (3) @(negedge clk);

        // Frame 3: a new frame of 20s starts with in_sof at old pixel (1,1).
        for (int i = 0; i < 5; i++) m_send(8'(i + 1), i == 0, -1);
        q_main.push_back(32'h00014); q_main.push_back(32'h00014);
        q_main.push_back(32'h00014); q_main.push_back(32'h10014);
        for (int i = 0; i < 16; i++) m_send(8'd20, i == 0, -1);
        repeat (3) @(negedge clk);

        // Frame 4: reset while an output is pending, then a frame without in_sof.
        m_or = 1'b0;
        for (int i = 0; i < 6; i++) m_send(8'(i + 1), i == 0, -1);
        @(negedge clk); n_rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(m_ov), 32'h0);
        @(negedge clk); n_rst = 1'b1; m_or = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", 32'(m_ir), 32'h1);
        push_std();
        for (int i = 0; i < 16; i++) m_send(8'(i + 1), 1'b0, -1);

        // 2x2 instances: signed and unsigned compare, ties, CH=2.
        q_s1.push_back(32'h100FF); q_s0.push_back(32'h100FF); q_c2.push_back(32'h10908);
        s_send(8'hFD, 16'h0901, 1'b1); s_send(8'hFF, 16'h0207, 1'b0);
        s_send(8'hFE, 16'h0303, 1'b0); s_send(8'hFC, 16'h0408, 1'b0);
        q_s1.push_back(32'h10001); q_s0.push_back(32'h10080); q_c2.push_back(32'h10706);
        s_send(8'h80, 16'h0102, 1'b1); s_send(8'h01, 16'h0304, 1'b0);
        s_send(8'h01, 16'h0506, 1'b0); s_send(8'h01, 16'h0700, 1'b0);
        q_s1.push_back(32'h10005); q_s0.push_back(32'h10005); q_c2.push_back(32'h10505);
        for (int i = 0; i < 4; i++) s_send(8'h05, 16'h0505, i == 0);

        t = 0;
        while ((q_main.size() + q_s1.size() + q_s0.size() + q_c2.size()) != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(q_main.size() + q_s1.size() + q_s0.size() + q_c2.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
